mem_port_master: RTL and testbench
==================================

MEM_PORT_MASTER -- requirements
Module: mem_port_master

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64, meaning the maximum number of cycles to wait for mem_ready per memory transaction.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port req_valid, input, 1 bit: cache request present.
REQ-005 SHALL have port req_ready, output, 1 bit: high exactly when the FSM is in IDLE.
REQ-006 SHALL have port req_wb, input, 1 bit: a dirty-line write-back is required.
REQ-007 SHALL have port req_rd, input, 1 bit: a line refill is required.
REQ-008 SHALL have ports req_wb_addr and req_rd_addr, inputs, 28 bits each [31:4]: line addresses.
REQ-009 SHALL have port req_wb_data, input, 128 bits: the victim line.
REQ-010 SHALL have port resp_valid, output, 1 bit: one-cycle completion pulse.
REQ-011 SHALL have port resp_data, output, 128 bits: the refill line.
REQ-012 SHALL have port resp_err, output, 1 bit: qualifies resp_valid and indicates a timeout abort.
REQ-013 SHALL have ports mem_read and mem_write, outputs, 1 bit each: slow-memory commands.
REQ-014 SHALL have port mem_addr, output, 28 bits [31:4]; mem_wdata, output, 128 bits; mem_rdata, input, 128 bits; and mem_ready, input, 1 bit.

Function
REQ-015 SHALL implement FSM states IDLE, WB, GAP, RD and DONE.
REQ-016 SHALL accept a request on a rising edge where req_valid and req_ready are both high, and latch all req_* fields at that edge; later input changes SHALL be ignored.
REQ-017 On accept: if req_wb, SHALL go to WB; else if req_rd, to RD; else to DONE with no memory traffic.
REQ-018 All mem_* outputs SHALL be registered: mem_write=1 exactly in WB; mem_read=1 exactly in RD; mem_read and mem_write SHALL never both be 1.
REQ-019 mem_addr and mem_wdata SHALL hold stable for the whole of WB or RD; mem_addr SHALL be 0 and mem_wdata held at its last value otherwise.
REQ-020 WB SHALL exit when mem_ready is sampled high: to GAP if req_rd was latched, else to DONE.
REQ-021 GAP SHALL last exactly one cycle with both commands low, then go to RD.
REQ-022 RD SHALL exit to DONE when mem_ready is sampled high, capturing mem_rdata into resp_data at that edge.
REQ-023 mem_ready sampled while no command is asserted SHALL be ignored.
REQ-024 A wait counter SHALL clear on entry to WB or RD and increment each cycle mem_ready is low.
REQ-025 When the counter reaches TIMEOUT, SHALL drop the command, go to DONE, set resp_err=1, set resp_data=0, and skip any pending read.
REQ-026 DONE SHALL last one cycle with resp_valid=1, then return to IDLE; resp_err=0 on a non-aborted completion.
REQ-027 For a write-only request, resp_data SHALL be 0.
REQ-028 Latency with responder latency L (mem_ready high on the L-th cycle of a command): read-only request accepted at edge T gives resp_valid in cycle T+L+1; write-back plus read gives resp_valid in cycle T+2L+2.

Reset
REQ-029 While rst is high, regardless of clk: state=IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_data=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0, and the counter=0.
REQ-030 Reset asserted mid-transaction SHALL abort it with no resp_valid; the first accept is possible on the first edge after rst falls.

Verification
REQ-031 Read-only, addr 0x0000010, L=5, rdata=0xDEADBEEF_...: mem_read high 5 cycles, resp_valid one cycle with that data, resp_err=0.
REQ-032 Write-back 0x0000020 with data 0x1234... plus read of 0x0000030: mem_write with correct addr/data, one GAP cycle, then mem_read at 0x0000030; never both commands high.
REQ-033 req_wb=req_rd=0: resp_valid on the cycle after accept, and mem_* stay 0.
REQ-034 mem_ready stuck low, TIMEOUT=64: command dropped after 64 cycles, resp_valid=1 with resp_err=1 and resp_data=0.
REQ-035 rst pulsed during WB: all outputs reset immediately, no resp_valid, and the next request completes normally.
REQ-036 Inputs changed after accept and spurious mem_ready while idle: there is no effect on mem_addr, mem_wdata or the FSM.

Source files
------------

// File: rtl/mem_port_master.sv
// -----------------------------------------------------------------------------
// mem_port_master
// Purpose: sequences one cache-miss service against a slow line-wide memory:
//          an optional dirty-line write-back, a one-cycle turnaround gap, then
//          an optional refill read, followed by a one-cycle completion pulse.
//          Each memory command is guarded by a TIMEOUT-cycle wait counter; an
//          expired command aborts the whole request with resp_err.
// Ports:
//   clk, rst                 clock and asynchronous active-high reset
//   req_valid / req_ready    request handshake (ready only while idle)
//   req_wb, req_rd           write-back / refill required
//   req_wb_addr, req_rd_addr line addresses [31:4]
//   req_wb_data              victim line
//   resp_valid               one-cycle completion pulse
//   resp_data                refill line (0 for write-only or aborted requests)
//   resp_err                 qualifies resp_valid: request aborted on timeout
//   mem_read, mem_write      registered memory commands (mutually exclusive)
//   mem_addr, mem_wdata      registered command address / write data
//   mem_rdata, mem_ready     memory read data / command completion
// -----------------------------------------------------------------------------
module mem_port_master #(
  parameter int TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_wb,
  input  logic         req_rd,
  input  logic [27:0]  req_wb_addr,
  input  logic [27:0]  req_rd_addr,
  input  logic [127:0] req_wb_data,
  output logic         resp_valid,
  output logic [127:0] resp_data,
  output logic         resp_err,
  output logic         mem_read,
  output logic         mem_write,
  output logic [27:0]  mem_addr,
  output logic [127:0] mem_wdata,
  input  logic [127:0] mem_rdata,
  input  logic         mem_ready
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WB,
    S_GAP,
    S_RD,
    S_DONE
  } state_t;

  state_t         r_state;
  state_t         w_state_next;

  logic           r_rd_pend;
  logic [27:0]    r_rd_addr;
  logic [CW-1:0]  r_cnt;
  logic           r_mem_read;
  logic           r_mem_write;
  logic [27:0]    r_mem_addr;
  logic [127:0]   r_mem_wdata;
  logic           r_resp_valid;
  logic           r_resp_err;
  logic [127:0]   r_resp_data;

  logic           w_accept;
  logic           w_cnt_last;
  logic           w_timeout;
  logic           w_rd_hit;
  logic           w_cmd_state;
  logic           w_cmd_entry;

  assign w_accept    = req_valid && (r_state == S_IDLE);
  // The command times out on the edge where the counter would reach TIMEOUT,
  // so a command is driven for at most TIMEOUT cycles. A ready on that very
  // last cycle still counts as a successful completion.
  assign w_cnt_last  = (r_cnt == CW'(TIMEOUT - 1));
  assign w_cmd_state = (r_state == S_WB) || (r_state == S_RD);
  assign w_cmd_entry = (w_state_next != r_state) &&
                       ((w_state_next == S_WB) || (w_state_next == S_RD));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_timeout    = 1'b0;
    w_rd_hit     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (req_wb)      w_state_next = S_WB;
          else if (req_rd) w_state_next = S_RD;
          else             w_state_next = S_DONE;
        end
      end
      S_WB: begin
        if (mem_ready) begin
          w_state_next = r_rd_pend ? S_GAP : S_DONE;
        end else if (w_cnt_last) begin
          // Abort skips any pending refill.
          w_state_next = S_DONE;
          w_timeout    = 1'b1;
        end
      end
      S_GAP: begin
        w_state_next = S_RD;
      end
      S_RD: begin
        if (mem_ready) begin
          w_state_next = S_DONE;
          w_rd_hit     = 1'b1;
        end else if (w_cnt_last) begin
          w_state_next = S_DONE;
          w_timeout    = 1'b1;
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Memory-side outputs are registered from the next state so they line up
  // exactly with the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_pend    <= 1'b0;
      r_rd_addr    <= '0;
      r_cnt        <= '0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_data  <= '0;
    end else begin
      if (w_accept) begin
        r_rd_pend   <= req_rd;
        r_rd_addr   <= req_rd_addr;
        r_resp_data <= '0;
        if (req_wb) begin
          r_mem_wdata <= req_wb_data;
        end
      end

      if (w_rd_hit) begin
        r_resp_data <= mem_rdata;
      end

      if (w_cmd_entry) begin
        r_cnt <= '0;
      end else if (w_cmd_state && !mem_ready) begin
        r_cnt <= r_cnt + 1'b1;
      end

      r_mem_write <= (w_state_next == S_WB);
      r_mem_read  <= (w_state_next == S_RD);

      // On entry from IDLE the latched copies are not yet valid, so the
      // address is taken straight from the request inputs at the accept edge.
      case (w_state_next)
        S_WB:    r_mem_addr <= (r_state == S_IDLE) ? req_wb_addr : r_mem_addr;
        S_RD:    r_mem_addr <= (r_state == S_IDLE) ? req_rd_addr : r_rd_addr;
        default: r_mem_addr <= '0;
      endcase

      r_resp_valid <= (w_state_next == S_DONE);
      r_resp_err   <= w_timeout;
    end
  end

  assign req_ready  = (r_state == S_IDLE);
  assign resp_valid = r_resp_valid;
  assign resp_err   = r_resp_err;
  assign resp_data  = r_resp_data;
  assign mem_read   = r_mem_read;
  assign mem_write  = r_mem_write;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_mem_port_master.sv
// -----------------------------------------------------------------------------
// tb_mem_port_master
// Purpose: self-checking bench for mem_port_master. A directed vector table
//          covers the named scenarios and timeout boundaries, a hand-written
//          sequence covers reset in the middle of a write-back, and random
//          requests are scored against a cycle-count model of the protocol.
// -----------------------------------------------------------------------------
module tb_mem_port_master;

  localparam int TO = 64;

  logic         clk;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic         req_wb;
  logic         req_rd;
  logic [27:0]  req_wb_addr;
  logic [27:0]  req_rd_addr;
  logic [127:0] req_wb_data;
  logic         resp_valid;
  logic [127:0] resp_data;
  logic         resp_err;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;

  int pass_cnt;
  int total_cnt;
  logic [127:0] last_wdata;

  mem_port_master #(.TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_wb      (req_wb),
    .req_rd      (req_rd),
    .req_wb_addr (req_wb_addr),
    .req_rd_addr (req_rd_addr),
    .req_wb_data (req_wb_data),
    .resp_valid  (resp_valid),
    .resp_data   (resp_data),
    .resp_err    (resp_err),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ready   (mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit           wb;
    bit           rd;
    logic [27:0]  wa;
    logic [27:0]  ra;
    logic [127:0] wd;
    logic [127:0] rdat;
    int           lwb;
    int           lrd;
    int           exp_cyc;
    int           exp_w;
    int           exp_r;
    bit           exp_err;
    bit           exp_data;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Issues one request and plays the memory responder: mem_ready is raised
  // on the L-th cycle of each command (never, if L exceeds the timeout).
  // Cycle c counts from 1 = first cycle after the accept edge.
  task automatic run_txn(input bit wb, input bit rd,
                         input logic [27:0] wa, input logic [27:0] ra,
                         input logic [127:0] wd, input logic [127:0] rdat,
                         input int lwb, input int lrd,
                         output int resp_cyc, output logic [127:0] rdata_o,
                         output logic err_o, output int wcyc, output int rcyc,
                         output int first_rd, output int proto_err);
    int guard;
    int wc;
    int rc;
    int valid_cnt;
    resp_cyc = 0; rdata_o = '0; err_o = 1'b0; wcyc = 0; rcyc = 0;
    first_rd = 0; proto_err = 0; wc = 0; rc = 0; valid_cnt = 0; guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) proto_err++;
    req_valid   = 1'b1;
    req_wb      = wb;
    req_rd      = rd;
    req_wb_addr = wa;
    req_rd_addr = ra;
    req_wb_data = wd;
    mem_rdata   = rdat;
    mem_ready   = 1'($urandom_range(0, 1));
    @(posedge clk);
    #1;
    // Scramble the request after acceptance; the DUT must ignore it.
    req_valid   = 1'b0;
    req_wb      = 1'($urandom_range(0, 1));
    req_rd      = 1'($urandom_range(0, 1));
    req_wb_addr = 28'($urandom);
    req_rd_addr = 28'($urandom);
    req_wb_data = {$urandom, $urandom, $urandom, $urandom};
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      if (mem_write && mem_read) proto_err++;
      if (mem_write) begin
        wcyc++;
        wc++;
        last_wdata = wd;
        if (mem_addr !== wa || mem_wdata !== wd) proto_err++;
        mem_ready = (wc == lwb);
      end else if (mem_read) begin
        rcyc++;
        rc++;
        if (first_rd == 0) first_rd = c;
        if (mem_addr !== ra || mem_wdata !== last_wdata) proto_err++;
        mem_ready = (rc == lrd);
      end else begin
        if (mem_addr !== 28'd0 || mem_wdata !== last_wdata) proto_err++;
        mem_ready = 1'($urandom_range(0, 1));
      end
      if (resp_valid) begin
        valid_cnt++;
        if (resp_cyc == 0) begin
          resp_cyc = c;
          rdata_o  = resp_data;
          err_o    = resp_err;
        end
      end
      if ((resp_cyc == 0 || c == resp_cyc) && req_ready) proto_err++;
      if (resp_cyc != 0 && c == resp_cyc + 1) begin
        if (!req_ready) proto_err++;
        break;
      end
    end
    if (valid_cnt != 1) proto_err++;
  endtask

  int           r_cyc;
  logic [127:0] r_data;
  logic         r_err;
  int           r_w;
  int           r_r;
  int           r_first;
  int           r_proto;

  initial begin
    pass_cnt    = 0;
    total_cnt   = 0;
    last_wdata  = '0;
    rst         = 1'b1;
    req_valid   = 1'b0;
    req_wb      = 1'b0;
    req_rd      = 1'b0;
    req_wb_addr = '0;
    req_rd_addr = '0;
    req_wb_data = '0;
    mem_rdata   = '0;
    mem_ready   = 1'b0;

    tbl[0] = '{0, 1, 28'h0, 28'h0000010, 128'h0,
               128'hDEADBEEF_CAFEF00D_0BADC0DE_FEEDFACE, 0, 5, 6, 0, 5, 0, 1};
    tbl[1] = '{1, 1, 28'h0000020, 28'h0000030,
               128'h12345678_9ABCDEF0_0FEDCBA9_87654321,
               128'hA5A5A5A5_5A5A5A5A_11112222_33334444, 3, 4, 9, 3, 4, 0, 1};
    tbl[2] = '{0, 0, 28'h0000040, 28'h0000050, 128'h77, 128'h88, 1, 1, 1, 0, 0, 0, 0};
    tbl[3] = '{0, 1, 28'h0, 28'h0000060, 128'h0, 128'h99, 0, 100, 65, 0, 64, 1, 0};
    tbl[4] = '{1, 0, 28'h0000070, 28'h0, 128'hCCCC_DDDD, 128'hEE, 2, 0, 3, 2, 0, 0, 0};
    tbl[5] = '{1, 1, 28'h0000080, 28'h0000090, 128'h1111, 128'h2222, 1, 1, 4, 1, 1, 0, 1};
    tbl[6] = '{0, 1, 28'h0, 28'h00000A0, 128'h0, 128'h3333_4444, 0, 64, 65, 0, 64, 0, 1};
    tbl[7] = '{1, 1, 28'h00000B0, 28'h00000C0, 128'h5555, 128'h6666, 100, 1, 65, 64, 0, 1, 0};
    tbl[8] = '{1, 1, 28'h00000D0, 28'h00000E0, 128'h7777, 128'h8888, 3, 100, 69, 3, 64, 1, 0};

    // Reset values, before any clock edge.
    #1;
    chk("rst_req_ready", 128'(req_ready), 128'd1);
    chk("rst_resp", {resp_valid, resp_err, resp_data}, 130'd0);
    chk("rst_mem_cmd", {mem_read, mem_write}, 128'd0);
    chk("rst_mem_addr", 128'(mem_addr), 128'd0);
    chk("rst_mem_wdata", mem_wdata, 128'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      run_txn(tbl[i].wb, tbl[i].rd, tbl[i].wa, tbl[i].ra, tbl[i].wd, tbl[i].rdat,
              tbl[i].lwb, tbl[i].lrd, r_cyc, r_data, r_err, r_w, r_r, r_first, r_proto);
      $display("vec %0d: wb=%0d rd=%0d resp_cyc=%0d wcyc=%0d rcyc=%0d err=%0d data=%0h",
               i, tbl[i].wb, tbl[i].rd, r_cyc, r_w, r_r, r_err, r_data);
      chk($sformatf("vec%0d_resp_cycle", i), 128'(r_cyc), 128'(tbl[i].exp_cyc));
      chk($sformatf("vec%0d_write_cycles", i), 128'(r_w), 128'(tbl[i].exp_w));
      chk($sformatf("vec%0d_read_cycles", i), 128'(r_r), 128'(tbl[i].exp_r));
      chk($sformatf("vec%0d_resp_err", i), 128'(r_err), 128'(tbl[i].exp_err));
      chk($sformatf("vec%0d_resp_data", i), r_data, tbl[i].exp_data ? tbl[i].rdat : 128'd0);
      chk($sformatf("vec%0d_protocol", i), 128'(r_proto), 128'd0);
    end

    // Reset pulsed in the middle of a write-back.
    begin
      int seen_valid;
      int guard;
      seen_valid = 0;
      guard = 0;
      @(negedge clk);
      while (!req_ready && guard < 100) begin
        @(negedge clk);
        guard++;
      end
      req_valid   = 1'b1;
      req_wb      = 1'b1;
      req_rd      = 1'b1;
      req_wb_addr = 28'h0000555;
      req_rd_addr = 28'h0000666;
      req_wb_data = 128'hFACE_B00C;
      mem_ready   = 1'b0;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("wb_before_reset", {mem_write, mem_read, mem_addr}, {2'b10, 28'h0000555});
      #2;
      rst = 1'b1;
      #1;
      chk("midrst_mem_cmd", {mem_read, mem_write}, 128'd0);
      chk("midrst_mem_addr_wdata", {mem_addr, mem_wdata}, 156'd0);
      chk("midrst_resp", {req_ready, resp_valid, resp_err, resp_data}, {1'b1, 130'd0});
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        if (resp_valid) seen_valid++;
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      last_wdata = '0;
      @(posedge clk);
      #1;
      if (resp_valid) seen_valid++;
      chk("midrst_no_resp_valid", 128'(seen_valid), 128'd0);
      run_txn(1'b1, 1'b1, 28'h0000777, 28'h0000888, 128'hABCD, 128'h1357_9BDF,
              2, 3, r_cyc, r_data, r_err, r_w, r_r, r_first, r_proto);
      $display("post-reset txn: resp_cyc=%0d err=%0d data=%0h", r_cyc, r_err, r_data);
      chk("postrst_resp_cycle", 128'(r_cyc), 128'd7);
      chk("postrst_resp_data", {r_err, r_data}, {1'b0, 128'h1357_9BDF});
      chk("postrst_protocol", 128'(r_proto), 128'd0);
    end

    // Random requests against a cycle-count model.
    for (int n = 0; n < 24; n++) begin
      bit           wb;
      bit           rd;
      logic [27:0]  wa;
      logic [27:0]  ra;
      logic [127:0] wd;
      logic [127:0] rdat;
      int           lwb;
      int           lrd;
      bit           wto;
      bit           rdo;
      bit           rto;
      int           ew;
      int           er;
      int           gap;
      wb   = 1'($urandom_range(0, 1));
      rd   = 1'($urandom_range(0, 1));
      wa   = 28'($urandom);
      ra   = 28'($urandom);
      wd   = {$urandom, $urandom, $urandom, $urandom};
      rdat = {$urandom, $urandom, $urandom, $urandom};
      lwb  = ($urandom_range(0, 7) == 0) ? 70 : int'($urandom_range(1, 8));
      lrd  = ($urandom_range(0, 7) == 0) ? 70 : int'($urandom_range(1, 8));
      wto  = wb && (lwb > TO);
      rdo  = rd && !wto;
      rto  = rdo && (lrd > TO);
      ew   = wb ? (wto ? TO : lwb) : 0;
      er   = rdo ? (rto ? TO : lrd) : 0;
      gap  = (wb && rdo) ? 1 : 0;
      run_txn(wb, rd, wa, ra, wd, rdat, lwb, lrd,
              r_cyc, r_data, r_err, r_w, r_r, r_first, r_proto);
      $display("rnd %0d: wb=%0d rd=%0d lwb=%0d lrd=%0d resp_cyc=%0d err=%0d",
               n, wb, rd, lwb, lrd, r_cyc, r_err);
      chk($sformatf("rnd%0d_resp_cycle", n), 128'(r_cyc), 128'(ew + gap + er + 1));
      chk($sformatf("rnd%0d_write_cycles", n), 128'(r_w), 128'(ew));
      chk($sformatf("rnd%0d_read_cycles", n), 128'(r_r), 128'(er));
      chk($sformatf("rnd%0d_first_read", n), 128'(r_first), 128'(rdo ? ew + gap + 1 : 0));
      chk($sformatf("rnd%0d_resp_err", n), 128'(r_err), 128'(wto || rto));
      chk($sformatf("rnd%0d_resp_data", n), r_data, (rdo && !rto) ? rdat : 128'd0);
      chk($sformatf("rnd%0d_protocol", n), 128'(r_proto), 128'd0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
